// File: rtl/mem_copy_master_if.sv
// rtl/mem_copy_master_if.sv - off-chip memory request/response bus
interface mem_copy_master_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              Mout_oe_ram;
    logic              Mout_we_ram;
    logic [ADDR_W-1:0] Mout_addr_ram;
    logic [DATA_W-1:0] Mout_Wdata_ram;
    logic [7:0]        Mout_data_ram_size;
    logic [DATA_W-1:0] M_Rdata_ram;
    logic              M_DataRdy;

    modport master (
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        input  M_Rdata_ram, M_DataRdy
    );

    modport slave (
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        output M_Rdata_ram, M_DataRdy
    );
endinterface

// File: rtl/mem_copy_master.sv
// rtl/mem_copy_master.sv - byte-by-byte memory copy initiator
module mem_copy_master #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_port,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    mem_copy_master_if.master mem,
    output logic              done_port,
    output logic              busy,
    output logic              err_timeout,
    output logic [LEN_W-1:0]  bytes_done
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] GAP_R = 3'd2;
    localparam logic [2:0] WR    = 3'd3;
    localparam logic [2:0] GAP_W = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [15:0]       WAIT_MAX = 16'(TIMEOUT - 1);
    localparam logic [7:0]        SIZE_BITS = 8'(DATA_W);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       wait_q, wait_d;
    logic              err_q, err_d;

    logic              oe_q, oe_d, we_q, we_d, done_q, done_d, busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        size_q, size_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_port) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = length;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    wait_d  = '0;
                    state_d = (length == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (mem.M_DataRdy) begin
                    data_d  = mem.M_Rdata_ram;
                    state_d = GAP_R;
                end else if (wait_q == WAIT_MAX) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            GAP_R: begin
                wait_d  = '0;
                state_d = WR;
            end
            WR: begin
                if (mem.M_DataRdy) begin
                    cnt_d   = cnt_q + LEN_ONE;
                    src_d   = src_q + ADDR_ONE;
                    dst_d   = dst_q + ADDR_ONE;
                    state_d = GAP_W;
                end else if (wait_q == WAIT_MAX) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            GAP_W: begin
                wait_d  = '0;
                state_d = (cnt_q == len_q) ? DONE : RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are derived from the next state so they are registered yet
    // line up with the state they belong to.
    always_comb begin
        oe_d    = (state_d == RD);
        we_d    = (state_d == WR);
        addr_d  = oe_d ? src_d : (we_d ? dst_d : '0);
        wdata_d = we_d ? data_d : '0;
        size_d  = (oe_d || we_d) ? SIZE_BITS : 8'd0;
        done_d  = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign mem.Mout_oe_ram        = oe_q;
    assign mem.Mout_we_ram        = we_q;
    assign mem.Mout_addr_ram      = addr_q;
    assign mem.Mout_Wdata_ram     = wdata_q;
    assign mem.Mout_data_ram_size = size_q;
    assign done_port              = done_q;
    assign busy                   = busy_q;
    assign err_timeout            = err_q;
    assign bytes_done             = cnt_q;
endmodule

// File: tb/tb_mem_copy_master.sv
// tb/tb_mem_copy_master.sv - directed bench for mem_copy_master
module tb_mem_copy_master;
    localparam int TO = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_port = 1'b0;
    logic [6:0] src_addr = '0;
    logic [6:0] dst_addr = '0;
    logic [7:0] length = '0;
    logic       done_port, busy, err_timeout;
    logic [7:0] bytes_done;

    mem_copy_master_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    mem_copy_master #(.ADDR_W(7), .DATA_W(8), .LEN_W(8), .TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_port (start_port),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .mem        (bus),
        .done_port  (done_port),
        .busy       (busy),
        .err_timeout(err_timeout),
        .bytes_done (bytes_done)
    );

    always #5 clock = ~clock;

    // Responder: ready in cycle rd_dly / wr_dly of a request, optional hang on one read address
    logic [7:0] mem [128];
    logic [7:0] exp_mem [128];
    int         rd_dly = 2, wr_dly = 1, req_cnt = 0;
    logic       hang_en = 1'b0;
    logic [6:0] hang_addr = '0;

    assign bus.M_DataRdy = (bus.Mout_oe_ram && !(hang_en && bus.Mout_addr_ram == hang_addr) && req_cnt == rd_dly - 1)
                        || (bus.Mout_we_ram && req_cnt == wr_dly - 1);
    assign bus.M_Rdata_ram = mem[bus.Mout_addr_ram];

    always @(posedge clock) begin
        if (bus.Mout_oe_ram || bus.Mout_we_ram) req_cnt <= req_cnt + 1;
        else req_cnt <= 0;
        if (bus.Mout_we_ram && bus.M_DataRdy) mem[bus.Mout_addr_ram] = bus.Mout_Wdata_ram;
    end

    // Bus monitor
    int         oe_run, we_run, oe_max, we_max, ovl, stab_err, done_cnt;
    logic       p_oe = 1'b0, p_we = 1'b0, p_rdy = 1'b0;
    logic [6:0] p_addr = '0;
    logic [7:0] p_wdata = '0, p_size = '0;
    logic [6:0] rd_q[$], wr_q[$];

    always @(negedge clock) begin
        assert (!(bus.Mout_oe_ram && bus.Mout_we_ram)) else $error("FAIL oe_we_overlap");
        if (bus.Mout_oe_ram && bus.Mout_we_ram) ovl++;
        if (bus.Mout_oe_ram) begin oe_run++; if (oe_run > oe_max) oe_max = oe_run; end else oe_run = 0;
        if (bus.Mout_we_ram) begin we_run++; if (we_run > we_max) we_max = we_run; end else we_run = 0;
        if ((p_oe || p_we) && !p_rdy && !err_timeout) begin
            if (bus.Mout_oe_ram != p_oe || bus.Mout_we_ram != p_we || bus.Mout_addr_ram != p_addr ||
                bus.Mout_Wdata_ram != p_wdata || bus.Mout_data_ram_size != p_size) stab_err++;
        end
        if (bus.Mout_oe_ram && bus.M_DataRdy) rd_q.push_back(bus.Mout_addr_ram);
        if (bus.Mout_we_ram && bus.M_DataRdy) wr_q.push_back(bus.Mout_addr_ram);
        if (done_port) done_cnt++;
        p_oe = bus.Mout_oe_ram; p_we = bus.Mout_we_ram; p_rdy = bus.M_DataRdy;
        p_addr = bus.Mout_addr_ram; p_wdata = bus.Mout_Wdata_ram; p_size = bus.Mout_data_ram_size;
    end

    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        oe_run = 0; we_run = 0; oe_max = 0; we_max = 0;
        ovl = 0; stab_err = 0; done_cnt = 0;
        rd_q.delete(); wr_q.delete();
    endtask

    task automatic init_mem();
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 5);
        mem[16] = 8'hA1; mem[17] = 8'hB2; mem[18] = 8'hC3; mem[19] = 8'hD4;
    endtask

    task automatic run_xfer(input logic [6:0] s, input logic [6:0] d, input logic [7:0] n,
                            input int budget, input int glitch_k, output int done_k);
        src_addr = s; dst_addr = d; length = n;
        @(negedge clock); #1;
        start_port = 1'b1;
        clear_mon();
        @(posedge clock); #1;
        start_port = 1'b0;
        done_k = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clock); #1;
            if (k == glitch_k) begin
                start_port = 1'b1; src_addr = 7'h33; length = 8'd0;
            end else begin
                start_port = 1'b0;
            end
            if (done_port) begin done_k = k; break; end
        end
        @(posedge clock); #1;
        start_port = 1'b0;
    endtask

    typedef struct {
        logic [6:0] src;
        logic [6:0] dst;
        logic [7:0] len;
        int         rd;
        int         wr;
        int         exp_done;
        int         exp_oe_run;
        int         exp_we_run;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int         dk, bad;
        logic [6:0] a;
        logic [7:0] saved_bd;

        vecs[0] = '{7'h20, 7'h30, 8'd0, 2, 1,  1, 0, 0};
        vecs[1] = '{7'h10, 7'h40, 8'd4, 2, 1, 21, 2, 1};
        vecs[2] = '{7'h50, 7'h60, 8'd2, 5, 3, 21, 5, 3};
        vecs[3] = '{7'h7E, 7'h00, 8'd3, 2, 1, 16, 2, 1};
        vecs[4] = '{7'h12, 7'h13, 8'd3, 1, 1, 13, 1, 1};

        init_mem();
        repeat (2) @(negedge clock);
        chk("reset_outputs", {bus.Mout_oe_ram, bus.Mout_we_ram, bus.Mout_addr_ram, bus.Mout_Wdata_ram,
                              bus.Mout_data_ram_size, done_port, busy, err_timeout, bytes_done}, 32'd0);
        #1 reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            init_mem();
            for (int i = 0; i < 128; i++) exp_mem[i] = mem[i];
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                a = vecs[v].dst + 7'(i);
                exp_mem[a] = exp_mem[vecs[v].src + 7'(i)];
            end
            rd_dly = vecs[v].rd; wr_dly = vecs[v].wr;
            run_xfer(vecs[v].src, vecs[v].dst, vecs[v].len, 200, 0, dk);
            chk($sformatf("v%0d_done_cycle", v), dk, vecs[v].exp_done);
            chk($sformatf("v%0d_bytes_done", v), bytes_done, 32'(vecs[v].len));
            chk($sformatf("v%0d_err", v), err_timeout, 0);
            repeat (3) @(negedge clock); #1;
            chk($sformatf("v%0d_done_pulses", v), done_cnt, 1);
            chk($sformatf("v%0d_oe_hold", v), oe_max, vecs[v].exp_oe_run);
            chk($sformatf("v%0d_we_hold", v), we_max, vecs[v].exp_we_run);
            chk($sformatf("v%0d_stable", v), stab_err, 0);
            chk($sformatf("v%0d_overlap", v), ovl, 0);
            bad = 0;
            if (rd_q.size() != int'(vecs[v].len) || wr_q.size() != int'(vecs[v].len)) bad++;
            else for (int i = 0; i < rd_q.size(); i++) begin
                if (rd_q[i] != vecs[v].src + 7'(i)) bad++;
                if (wr_q[i] != vecs[v].dst + 7'(i)) bad++;
            end
            chk($sformatf("v%0d_addr_seq", v), bad, 0);
            bad = 0;
            for (int i = 0; i < 128; i++) if (mem[i] !== exp_mem[i]) bad++;
            chk($sformatf("v%0d_mem_image", v), bad, 0);
        end

        // Timeout on the second read
        init_mem();
        rd_dly = 2; wr_dly = 1; hang_en = 1'b1; hang_addr = 7'h11;
        run_xfer(7'h10, 7'h48, 8'd3, 200, 0, dk);
        chk("to_done_cycle", dk, 12);
        chk("to_err", err_timeout, 1);
        chk("to_bytes_done", bytes_done, 1);
        chk("to_oe_hold", oe_max, TO);
        chk("to_mem_first", mem[7'h48], 8'hA1);
        chk("to_mem_untouched", mem[7'h49], 8'(7'h49 * 37 + 5));
        hang_en = 1'b0;
        run_xfer(7'h00, 7'h00, 8'd0, 20, 0, dk);
        chk("to_clear_done", dk, 1);
        chk("to_clear_err", err_timeout, 0);

        // Reset during WR of byte 2
        init_mem();
        rd_dly = 2; wr_dly = 3;
        src_addr = 7'h10; dst_addr = 7'h50; length = 8'd4;
        @(negedge clock); #1 start_port = 1'b1;
        clear_mon();
        @(posedge clock); #1 start_port = 1'b0;
        dk = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock); #1;
            if (bus.Mout_we_ram && bus.Mout_addr_ram == 7'h51) begin dk = k; break; end
        end
        chk("rst_reach_wr2", dk != 0, 1);
        saved_bd = bytes_done;
        chk("rst_bytes_before", saved_bd, 1);
        reset = 1'b1;
        @(negedge clock); #1;
        chk("rst_outputs", {bus.Mout_oe_ram, bus.Mout_we_ram, bus.Mout_addr_ram, bus.Mout_Wdata_ram,
                            bus.Mout_data_ram_size, done_port, busy, err_timeout, bytes_done}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock); #1;
        chk("rst_no_done", done_cnt, 0);
        chk("rst_idle", busy, 0);

        init_mem();
        rd_dly = 2; wr_dly = 1;
        run_xfer(7'h20, 7'h58, 8'd2, 100, 3, dk);
        chk("post_rst_done_cycle", dk, 11);
        chk("post_rst_bytes", bytes_done, 2);
        chk("post_rst_copy", {mem[7'h58], mem[7'h59]}, {8'(7'h20 * 37 + 5), 8'(7'h21 * 37 + 5)});
        run_xfer(7'h10, 7'h70, 8'd1, 100, 6, dk);
        chk("start_in_done_cycle", dk, 6);
        @(negedge clock); #1;
        chk("start_in_done_idle", busy, 0);
        repeat (3) @(negedge clock); #1;
        chk("start_in_done_pulses", done_cnt, 1);
        chk("start_in_done_copy", mem[7'h70], 8'hA1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
